// File: rtl/dram_arbiter.sv
// Shares the DRAM sequencer between the 68000 bus, a DMA master and refresh.
// One request at a time over REQ/DONE; refresh timing and its postponement budget live here.
module dram_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int URGENT_LEVEL     = 2,
  parameter int CNT_WIDTH        = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_AS,
  input  logic        CPU_CS,
  input  logic        CPU_RW,
  input  logic        CPU_UDS,
  input  logic        CPU_LDS,
  input  logic [22:0] CPU_ADDR,
  output logic        DTACK_CPU,
  input  logic        DMA_REQ,
  input  logic        DMA_RW,
  input  logic [1:0]  DMA_BE,
  input  logic [22:0] DMA_ADDR,
  output logic        DMA_ACK,
  output logic        MEM_REQ,
  output logic        MEM_REFRESH,
  output logic [22:0] MEM_ADDR,
  output logic        MEM_RW,
  output logic        MEM_UDS,
  output logic        MEM_LDS,
  input  logic        MEM_DONE,
  output logic [1:0]  GRANT,
  output logic        REFRESH_OVERRUN
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_HOLD, DMA_ACC, REF_ACC} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_CPU  = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_REF  = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REFRESH_INTERVAL - 1);
  localparam logic [1:0] URGENT = 2'(URGENT_LEVEL);

  state_t               state;
  logic                 as_q;
  logic                 cs_q;
  logic                 last_cpu;
  logic [CNT_WIDTH-1:0] counter;
  logic [1:0]           pending;
  logic [1:0]           pick;
  logic                 cpu_req;
  logic                 wrap;
  logic                 ref_done;

  assign cpu_req  = ~as_q & ~cs_q;
  assign wrap     = (counter == CNT_LAST);
  assign ref_done = (state == REF_ACC) && MEM_DONE;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      as_q <= 1'b1;
      cs_q <= 1'b1;
    end else begin
      as_q <= CPU_AS;
      cs_q <= CPU_CS;
    end
  end

  // A wrap and a refresh completion on the same edge cancel out.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      counter         <= '0;
      pending         <= 2'd0;
      REFRESH_OVERRUN <= 1'b0;
    end else begin
      counter <= wrap ? '0 : counter + 1'b1;
      if (wrap && pending == 2'd3)
        REFRESH_OVERRUN <= 1'b1;
      if (wrap && !ref_done && pending != 2'd3)
        pending <= pending + 2'd1;
      else if (!wrap && ref_done)
        pending <= pending - 2'd1;
    end
  end

  always_comb begin
    pick = G_NONE;
    if (pending >= URGENT)
      pick = G_REF;
    else if (cpu_req && DMA_REQ)
      pick = last_cpu ? G_DMA : G_CPU;
    else if (cpu_req)
      pick = G_CPU;
    else if (DMA_REQ)
      pick = G_DMA;
    else if (pending != 2'd0)
      pick = G_REF;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      last_cpu    <= 1'b0;
      DTACK_CPU   <= 1'b1;
      DMA_ACK     <= 1'b0;
      MEM_REQ     <= 1'b0;
      MEM_REFRESH <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_RW      <= 1'b1;
      MEM_UDS     <= 1'b1;
      MEM_LDS     <= 1'b1;
      GRANT       <= G_NONE;
    end else begin
      DMA_ACK <= 1'b0;
      case (state)
        IDLE: begin
          case (pick)
            G_CPU: begin
              MEM_REQ  <= 1'b1;
              GRANT    <= G_CPU;
              MEM_ADDR <= CPU_ADDR;
              MEM_RW   <= CPU_RW;
              MEM_UDS  <= CPU_UDS;
              MEM_LDS  <= CPU_LDS;
              state    <= CPU_ACC;
            end
            G_DMA: begin
              MEM_REQ  <= 1'b1;
              GRANT    <= G_DMA;
              MEM_ADDR <= DMA_ADDR;
              MEM_RW   <= DMA_RW;
              MEM_UDS  <= ~DMA_BE[1];
              MEM_LDS  <= ~DMA_BE[0];
              state    <= DMA_ACC;
            end
            G_REF: begin
              // Refresh keeps the last address; byte strobes stay inactive.
              MEM_REQ     <= 1'b1;
              MEM_REFRESH <= 1'b1;
              GRANT       <= G_REF;
              MEM_RW      <= 1'b1;
              MEM_UDS     <= 1'b1;
              MEM_LDS     <= 1'b1;
              state       <= REF_ACC;
            end
            default: ;
          endcase
        end
        CPU_ACC: begin
          if (MEM_DONE) begin
            if (as_q) begin
              MEM_REQ  <= 1'b0;
              GRANT    <= G_NONE;
              last_cpu <= 1'b1;
              state    <= IDLE;
            end else begin
              DTACK_CPU <= 1'b0;
              state     <= CPU_HOLD;
            end
          end
        end
        CPU_HOLD: begin
          if (as_q) begin
            DTACK_CPU <= 1'b1;
            MEM_REQ   <= 1'b0;
            GRANT     <= G_NONE;
            last_cpu  <= 1'b1;
            state     <= IDLE;
          end
        end
        DMA_ACC: begin
          if (MEM_DONE) begin
            MEM_REQ  <= 1'b0;
            DMA_ACK  <= 1'b1;
            GRANT    <= G_NONE;
            last_cpu <= 1'b0;
            state    <= IDLE;
          end
        end
        REF_ACC: begin
          if (MEM_DONE) begin
            MEM_REQ     <= 1'b0;
            MEM_REFRESH <= 1'b0;
            GRANT       <= G_NONE;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: requester queues, a sequencer model and a refresh budget model.
module tb_dram_arbiter;

  localparam int INTERVAL = 16;
  localparam int URGENT   = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CPU_AS, CPU_CS, CPU_RW, CPU_UDS, CPU_LDS;
  logic [22:0] CPU_ADDR;
  logic        DTACK_CPU;
  logic        DMA_REQ, DMA_RW;
  logic [1:0]  DMA_BE;
  logic [22:0] DMA_ADDR;
  logic        DMA_ACK;
  logic        MEM_REQ, MEM_REFRESH, MEM_RW, MEM_UDS, MEM_LDS;
  logic [22:0] MEM_ADDR;
  logic        MEM_DONE;
  logic [1:0]  GRANT;
  logic        REFRESH_OVERRUN;

  always #5 CLK = ~CLK;

  dram_arbiter #(
    .REFRESH_INTERVAL(INTERVAL),
    .URGENT_LEVEL(URGENT),
    .CNT_WIDTH(12)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CPU_AS(CPU_AS), .CPU_CS(CPU_CS), .CPU_RW(CPU_RW),
    .CPU_UDS(CPU_UDS), .CPU_LDS(CPU_LDS), .CPU_ADDR(CPU_ADDR),
    .DTACK_CPU(DTACK_CPU),
    .DMA_REQ(DMA_REQ), .DMA_RW(DMA_RW), .DMA_BE(DMA_BE), .DMA_ADDR(DMA_ADDR),
    .DMA_ACK(DMA_ACK),
    .MEM_REQ(MEM_REQ), .MEM_REFRESH(MEM_REFRESH), .MEM_ADDR(MEM_ADDR),
    .MEM_RW(MEM_RW), .MEM_UDS(MEM_UDS), .MEM_LDS(MEM_LDS),
    .MEM_DONE(MEM_DONE), .GRANT(GRANT), .REFRESH_OVERRUN(REFRESH_OVERRUN)
  );

  typedef struct packed {
    logic [22:0] addr;
    logic        rw;
    logic        uds;
    logic        lds;
  } acc_t;

  acc_t        cpu_q[$];
  acc_t        dma_q[$];
  int          grant_log[$];
  int          ref_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cyc = -1;
  int          pend_model = 0;
  int          pend_before = 0;
  bit          ovr_model = 1'b0;
  int          ack_cnt = 0;
  int          urgent_cnt = 0;
  int          done_delay = 3;
  bit          rand_delay = 1'b0;
  bit          stall = 1'b0;
  bit          ref_flag = 1'b0;
  bit          rst_seen = 1'b0;
  logic [22:0] last_addr = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Refresh budget model: wraps every INTERVAL cycles, each completed refresh pays one back.
  initial begin
    forever begin
      @(posedge CLK);
      pend_before = pend_model;
      rst_seen    = RST;
      if (!RST) begin
        cyc        = 0;
        pend_model = 0;
        ovr_model  = 1'b0;
        last_addr  = '0;
      end else begin
        cyc++;
        if (MEM_DONE) done_cyc = cyc;
        if ((cyc % INTERVAL) == 0) begin
          if (pend_model == 3) ovr_model = 1'b1;
          pend_model++;
        end
        if (MEM_DONE && ref_flag) pend_model--;
        if (pend_model > 3) pend_model = 3;
      end
    end
  end

  // Sequencer model: one DONE pulse per MEM_REQ rise, after a programmable delay.
  initial begin
    bit busy;
    bit served;
    bit is_ref;
    int cnt;
    busy = 1'b0; served = 1'b0; is_ref = 1'b0; cnt = 0;
    MEM_DONE = 1'b0;
    forever begin
      @(negedge CLK);
      MEM_DONE = 1'b0;
      ref_flag = 1'b0;
      if (!MEM_REQ) begin
        busy   = 1'b0;
        served = 1'b0;
      end else if (!busy) begin
        busy   = 1'b1;
        cnt    = rand_delay ? int'($urandom_range(1, 4)) : done_delay;
        is_ref = MEM_REFRESH;
      end else if (!served && !stall) begin
        cnt--;
        if (cnt <= 0) begin
          MEM_DONE = 1'b1;
          ref_flag = is_ref;
          served   = 1'b1;
        end
      end
    end
  end

  // Monitor: every new MEM_REQ is matched against the queue of the granted requester.
  initial begin
    logic prev_req;
    logic prev_ack;
    acc_t e;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge CLK);
      if (!rst_seen) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (MEM_REQ && !prev_req) begin
          grant_log.push_back(int'(GRANT));
          case (GRANT)
            2'd1, 2'd2: begin
              checkOutput("access_refresh_flag", 32'(MEM_REFRESH), 32'(0));
              checkOutput("access_not_urgent", 32'(pend_before < URGENT), 32'(1));
              if (GRANT == 2'd1) begin
                checkOutput("cpu_q_nonempty", 32'(cpu_q.size() > 0), 32'(1));
                if (cpu_q.size() > 0) e = cpu_q.pop_front();
                else e = '0;
              end else begin
                checkOutput("dma_q_nonempty", 32'(dma_q.size() > 0), 32'(1));
                if (dma_q.size() > 0) e = dma_q.pop_front();
                else e = '0;
              end
              checkOutput("mem_addr", 32'(MEM_ADDR), 32'(e.addr));
              checkOutput("mem_rw", 32'(MEM_RW), 32'(e.rw));
              checkOutput("mem_uds", 32'(MEM_UDS), 32'(e.uds));
              checkOutput("mem_lds", 32'(MEM_LDS), 32'(e.lds));
              last_addr = e.addr;
            end
            2'd3: begin
              ref_log.push_back(cyc);
              if (pend_before >= URGENT) urgent_cnt++;
              checkOutput("refresh_flag", 32'(MEM_REFRESH), 32'(1));
              checkOutput("refresh_rw", 32'(MEM_RW), 32'(1));
              checkOutput("refresh_addr_hold", 32'(MEM_ADDR), 32'(last_addr));
              checkOutput("refresh_has_pending", 32'(pend_before >= 1), 32'(1));
            end
            default: checkOutput("grant_nonzero", 32'(GRANT != 2'd0), 32'(1));
          endcase
        end
        if (DMA_ACK) begin
          ack_cnt++;
          checkOutput("dma_ack_width", 32'(prev_ack), 32'(0));
        end
        prev_req = MEM_REQ;
        prev_ack = DMA_ACK;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  task automatic holdReset();
    RST     = 1'b0;
    CPU_AS  = 1'b1;
    CPU_CS  = 1'b1;
    DMA_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    cpu_q.delete();
    dma_q.delete();
    grant_log.delete();
    ref_log.delete();
    ack_cnt    = 0;
    urgent_cnt = 0;
  endtask

  task automatic waitDtack(input logic level, input string name);
    int k;
    k = 0;
    while (DTACK_CPU !== level && k < 60) begin
      @(negedge CLK);
      k++;
    end
    checkOutput(name, 32'(DTACK_CPU), 32'(level));
  endtask

  task automatic applyStimulus(input logic [22:0] addr, input logic rw, input logic uds,
                               input logic lds, input int hold);
    acc_t e;
    e.addr = addr; e.rw = rw; e.uds = uds; e.lds = lds;
    cpu_q.push_back(e);
    CPU_ADDR = addr; CPU_RW = rw; CPU_UDS = uds; CPU_LDS = lds;
    CPU_AS = 1'b0; CPU_CS = 1'b0;
    waitDtack(1'b0, "cpu_dtack_low");
    repeat (hold) @(negedge CLK);
    CPU_AS = 1'b1; CPU_CS = 1'b1;
    waitDtack(1'b1, "cpu_dtack_high");
  endtask

  task automatic cpuStream(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        CPU_ADDR = 23'($urandom);
        CPU_AS = 1'b0; CPU_CS = 1'b1;
        repeat (3) @(negedge CLK);
        CPU_AS = 1'b1;
      end else begin
        s = int'($urandom_range(0, 2));
        applyStimulus(23'($urandom), 1'($urandom), s == 2, s == 1, int'($urandom_range(0, 2)));
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic dmaStream(input int n);
    acc_t e;
    int   k;
    for (int i = 0; i < n; i++) begin
      DMA_ADDR = 23'($urandom);
      DMA_RW   = 1'($urandom);
      DMA_BE   = 2'($urandom_range(1, 3));
      e.addr = DMA_ADDR; e.rw = DMA_RW; e.uds = ~DMA_BE[1]; e.lds = ~DMA_BE[0];
      dma_q.push_back(e);
      DMA_REQ = 1'b1;
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!DMA_ACK && k < 80);
      checkOutput("dma_ack_seen", 32'(DMA_ACK), 32'(1));
    end
    DMA_REQ = 1'b0;
  endtask

  initial begin
    int   k;
    acc_t e;
    RST = 1'b0; CPU_AS = 1'b1; CPU_CS = 1'b1; CPU_RW = 1'b1;
    CPU_UDS = 1'b1; CPU_LDS = 1'b1; CPU_ADDR = '0;
    DMA_REQ = 1'b0; DMA_RW = 1'b1; DMA_BE = 2'b00; DMA_ADDR = '0;
    @(negedge CLK);

    // Reset values and a single uncontended CPU read of byte address 0x000100.
    holdReset();
    checkOutput("rst_dtack", 32'(DTACK_CPU), 32'(1));
    checkOutput("rst_dma_ack", 32'(DMA_ACK), 32'(0));
    checkOutput("rst_mem_req", 32'(MEM_REQ), 32'(0));
    checkOutput("rst_mem_refresh", 32'(MEM_REFRESH), 32'(0));
    checkOutput("rst_mem_addr", 32'(MEM_ADDR), 32'(0));
    checkOutput("rst_mem_rw", 32'(MEM_RW), 32'(1));
    checkOutput("rst_mem_uds", 32'(MEM_UDS), 32'(1));
    checkOutput("rst_mem_lds", 32'(MEM_LDS), 32'(1));
    checkOutput("rst_grant", 32'(GRANT), 32'(0));
    checkOutput("rst_overrun", 32'(REFRESH_OVERRUN), 32'(0));
    RST = 1'b1;
    @(negedge CLK);
    e.addr = 23'h000080; e.rw = 1'b1; e.uds = 1'b0; e.lds = 1'b0;
    cpu_q.push_back(e);
    CPU_ADDR = 23'h000080; CPU_RW = 1'b1; CPU_UDS = 1'b0; CPU_LDS = 1'b0;
    CPU_AS = 1'b0; CPU_CS = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!MEM_REQ && k < 20);
    checkOutput("cpu_req_latency", 32'(k), 32'(2));
    checkOutput("cpu_grant", 32'(GRANT), 32'(1));
    waitDtack(1'b0, "cpu_dtack_low");
    checkOutput("dtack_after_done", 32'(cyc - done_cyc), 32'(0));
    CPU_AS = 1'b1; CPU_CS = 1'b1;
    @(negedge CLK);
    checkOutput("dtack_held", 32'(DTACK_CPU), 32'(0));
    @(negedge CLK);
    checkOutput("release_dtack", 32'(DTACK_CPU), 32'(1));
    checkOutput("release_mem_req", 32'(MEM_REQ), 32'(0));
    checkOutput("release_grant", 32'(GRANT), 32'(0));

    // CPU and DMA arrive at the arbiter together: CPU first, then DMA.
    holdReset();
    RST = 1'b1;
    @(negedge CLK);
    e.addr = 23'h000040; e.rw = 1'b0; e.uds = 1'b0; e.lds = 1'b1;
    cpu_q.push_back(e);
    CPU_ADDR = e.addr; CPU_RW = 1'b0; CPU_UDS = 1'b0; CPU_LDS = 1'b1;
    CPU_AS = 1'b0; CPU_CS = 1'b0;
    @(negedge CLK);
    DMA_ADDR = 23'h001234; DMA_RW = 1'b0; DMA_BE = 2'b01;
    e.addr = 23'h001234; e.rw = 1'b0; e.uds = 1'b1; e.lds = 1'b0;
    dma_q.push_back(e);
    DMA_REQ = 1'b1;
    waitDtack(1'b0, "arb_cpu_dtack");
    CPU_AS = 1'b1; CPU_CS = 1'b1;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!DMA_ACK && k < 40);
    checkOutput("arb_dma_ack", 32'(DMA_ACK), 32'(1));
    DMA_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("arb_ack_count", 32'(ack_cnt), 32'(1));
    checkOutput("arb_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 0), 32'(1));
    checkOutput("arb_second_grant", 32'(grant_log.size() > 1 ? grant_log[1] : 0), 32'(2));

    // Idle bus: a refresh every interval, each paying its pending count back.
    done_delay = 2;
    holdReset();
    RST = 1'b1;
    while (cyc < 52) @(negedge CLK);
    checkOutput("idle_ref_count", 32'(ref_log.size()), 32'(3));
    checkOutput("idle_ref0", 32'(ref_log.size() > 0 ? ref_log[0] : 0), 32'(17));
    checkOutput("idle_ref1", 32'(ref_log.size() > 1 ? ref_log[1] : 0), 32'(33));
    checkOutput("idle_ref2", 32'(ref_log.size() > 2 ? ref_log[2] : 0), 32'(49));

    // Continuous random traffic: refresh may only win once it becomes urgent.
    holdReset();
    RST = 1'b1;
    rand_delay = 1'b1;
    fork
      cpuStream(20);
      dmaStream(20);
    join
    rand_delay = 1'b0;
    repeat (10) @(negedge CLK);
    checkOutput("traffic_cpu_drained", 32'(cpu_q.size()), 32'(0));
    checkOutput("traffic_dma_drained", 32'(dma_q.size()), 32'(0));
    checkOutput("traffic_ack_count", 32'(ack_cnt), 32'(20));
    checkOutput("traffic_urgent_refresh", 32'(urgent_cnt > 0), 32'(1));
    checkOutput("traffic_no_overrun", 32'(REFRESH_OVERRUN), 32'(ovr_model));

    // Sequencer stalls a refresh: the budget saturates and overrun latches.
    done_delay = 3;
    stall = 1'b1;
    holdReset();
    RST = 1'b1;
    while (cyc < 55) @(negedge CLK);
    checkOutput("stall_grant_ref", 32'(GRANT), 32'(3));
    checkOutput("stall_no_overrun_yet", 32'(REFRESH_OVERRUN), 32'(0));
    while (cyc < 70) @(negedge CLK);
    checkOutput("stall_overrun_set", 32'(REFRESH_OVERRUN), 32'(1));
    stall = 1'b0;
    while (cyc < 110) @(negedge CLK);
    checkOutput("overrun_sticky", 32'(REFRESH_OVERRUN), 32'(1));
    holdReset();
    checkOutput("overrun_cleared", 32'(REFRESH_OVERRUN), 32'(0));
    RST = 1'b1;

    // Reset while the CPU holds DTACK, with a refresh pending and the counter mid-interval.
    holdReset();
    RST = 1'b1;
    while (cyc < 26) @(negedge CLK);
    e.addr = 23'h000155; e.rw = 1'b1; e.uds = 1'b0; e.lds = 1'b0;
    cpu_q.push_back(e);
    CPU_ADDR = e.addr; CPU_RW = 1'b1; CPU_UDS = 1'b0; CPU_LDS = 1'b0;
    CPU_AS = 1'b0; CPU_CS = 1'b0;
    waitDtack(1'b0, "hold_dtack_low");
    while (cyc < 36) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("midreset_dtack", 32'(DTACK_CPU), 32'(1));
    checkOutput("midreset_mem_req", 32'(MEM_REQ), 32'(0));
    checkOutput("midreset_grant", 32'(GRANT), 32'(0));
    holdReset();
    RST = 1'b1;
    while (cyc < 22) @(negedge CLK);
    checkOutput("midreset_ref_count", 32'(ref_log.size()), 32'(1));
    checkOutput("midreset_ref_time", 32'(ref_log.size() > 0 ? ref_log[0] : 0), 32'(17));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
